// File: rtl/vec_alu_sequencer.sv
`default_nettype none
// vec_alu_sequencer -- streams VRF element pairs through the ALU and writes results back. Rev 1.0
// Build option: define VEC_SEQ_OVF_TRAP_EN to abort on the first overflowing element.
module vec_alu_sequencer #(
  parameter int vdw_p        = 32,
  parameter int op_width_p   = 1,
  parameter int els_p        = 16,
  parameter int addr_width_p = 4
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        v_i,
  output logic                        ready_o,
  input  logic [op_width_p-1:0]       op_i,
  input  logic [$clog2(els_p+1)-1:0]  vlen_i,
  input  logic [addr_width_p-1:0]     vd_i,
  input  logic [addr_width_p-1:0]     vs1_i,
  input  logic [addr_width_p-1:0]     vs2_i,
  output logic                        rd_v_o,
  output logic [addr_width_p-1:0]     rd_reg_a_o,
  output logic [addr_width_p-1:0]     rd_reg_b_o,
  output logic [$clog2(els_p)-1:0]    rd_el_o,
  input  logic [vdw_p-1:0]            rd_data_a_i,
  input  logic [vdw_p-1:0]            rd_data_b_i,
  output logic [vdw_p-1:0]            alu_a_o,
  output logic [vdw_p-1:0]            alu_b_o,
  output logic [op_width_p-1:0]       alu_op_o,
  input  logic [vdw_p-1:0]            alu_result_i,
  input  logic                        alu_overflow_i,
  input  logic                        alu_zero_i,
  input  logic                        alu_negative_i,
  output logic                        wr_v_o,
  output logic [addr_width_p-1:0]     wr_reg_o,
  output logic [$clog2(els_p)-1:0]    wr_el_o,
  output logic [vdw_p-1:0]            wr_data_o,
  output logic                        done_v_o,
  input  logic                        done_yumi_i,
  output logic                        flag_overflow_o,
  output logic                        flag_all_zero_o,
  output logic                        flag_any_negative_o,
  output logic                        trap_o,
  output logic [$clog2(els_p)-1:0]    trap_el_o
);

  localparam int VLW = $clog2(els_p + 1);
  localparam int ELW = $clog2(els_p);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e                  state_q;
  logic                    ready_q, done_v_q;
  logic [op_width_p-1:0]   op_q, alu_op_q;
  logic [addr_width_p-1:0] vd_q, vs1_q, vs2_q;
  logic [VLW-1:0]          vlen_q;
  logic                    rd_v_q, s1_v_q, alu_v_q, wr_v_q;
  logic [ELW-1:0]          rd_el_q, s1_el_q, alu_el_q, wr_el_q, trap_el_q;
  logic [vdw_p-1:0]        alu_a_q, alu_b_q, wr_data_q;
  logic                    ovf_q, zero_q, neg_q, trap_q;

  logic [VLW-1:0] vlen_clamp;
  logic           last_rd;
  logic           pipe_last;
  logic           trap_hit;

  assign vlen_clamp = (vlen_i > VLW'(els_p)) ? VLW'(els_p) : vlen_i;
  assign last_rd    = (VLW'(rd_el_q) == (vlen_q - VLW'(1)));
  // The write now on the port is the final one when nothing is left behind it.
  assign pipe_last  = wr_v_q & ~rd_v_q & ~s1_v_q & ~alu_v_q;

`ifdef VEC_SEQ_OVF_TRAP_EN
  assign trap_hit = alu_v_q & alu_overflow_i & ~trap_q;
`else
  assign trap_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      ready_q   <= 1'b1;
      done_v_q  <= 1'b0;
      op_q      <= '0;
      vd_q      <= '0;
      vs1_q     <= '0;
      vs2_q     <= '0;
      vlen_q    <= '0;
      rd_v_q    <= 1'b0;
      rd_el_q   <= '0;
      s1_v_q    <= 1'b0;
      s1_el_q   <= '0;
      alu_v_q   <= 1'b0;
      alu_el_q  <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      wr_v_q    <= 1'b0;
      wr_el_q   <= '0;
      wr_data_q <= '0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b1;
      neg_q     <= 1'b0;
      trap_q    <= 1'b0;
      trap_el_q <= '0;
    end else begin
      // Elements behind a trapping element are squashed before they reach the write port.
      s1_v_q  <= rd_v_q & ~trap_hit;
      s1_el_q <= rd_el_q;
      alu_v_q <= s1_v_q & ~trap_hit;
      if (s1_v_q) begin
        alu_a_q  <= rd_data_a_i;
        alu_b_q  <= rd_data_b_i;
        alu_op_q <= op_q;
        alu_el_q <= s1_el_q;
      end
      wr_v_q <= alu_v_q;
      if (alu_v_q) begin
        wr_el_q   <= alu_el_q;
        wr_data_q <= alu_result_i;
        ovf_q     <= ovf_q | alu_overflow_i;
        zero_q    <= zero_q & alu_zero_i;
        neg_q     <= neg_q | alu_negative_i;
      end
      if (trap_hit) begin
        trap_q    <= 1'b1;
        trap_el_q <= alu_el_q;
      end

      case (state_q)
        IDLE: begin
          if (v_i && ready_q) begin
            op_q      <= op_i;
            vd_q      <= vd_i;
            vs1_q     <= vs1_i;
            vs2_q     <= vs2_i;
            vlen_q    <= vlen_clamp;
            ready_q   <= 1'b0;
            rd_el_q   <= '0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b1;
            neg_q     <= 1'b0;
            trap_q    <= 1'b0;
            trap_el_q <= '0;
            if (vlen_clamp == '0) begin
              state_q  <= DONE;
              done_v_q <= 1'b1;
            end else begin
              state_q <= RUN;
              rd_v_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (trap_hit || last_rd) begin
            rd_v_q  <= 1'b0;
            state_q <= DRAIN;
          end else begin
            rd_el_q <= rd_el_q + 1'b1;
          end
        end
        DRAIN: begin
          if (pipe_last) begin
            state_q  <= DONE;
            done_v_q <= 1'b1;
          end
        end
        DONE: begin
          if (done_yumi_i) begin
            done_v_q <= 1'b0;
            ready_q  <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o             = ready_q;
  assign rd_v_o              = rd_v_q;
  assign rd_reg_a_o          = vs1_q;
  assign rd_reg_b_o          = vs2_q;
  assign rd_el_o             = rd_el_q;
  assign alu_a_o             = alu_a_q;
  assign alu_b_o             = alu_b_q;
  assign alu_op_o            = alu_op_q;
  assign wr_v_o              = wr_v_q;
  assign wr_reg_o            = vd_q;
  assign wr_el_o             = wr_el_q;
  assign wr_data_o           = wr_data_q;
  assign done_v_o            = done_v_q;
  assign flag_overflow_o     = ovf_q;
  assign flag_all_zero_o     = zero_q;
  assign flag_any_negative_o = neg_q;
  assign trap_o              = trap_q;
  assign trap_el_o           = trap_el_q;

endmodule
`default_nettype wire

// File: tb/tb_vec_alu_sequencer.sv
`default_nettype none
// tb_vec_alu_sequencer -- bench with VRF/ALU models and an element-level reference model.
module tb_vec_alu_sequencer;

  localparam int VDW = 32;
  localparam int OPW = 1;
  localparam int ELS = 16;
  localparam int AW  = 4;
  localparam int VLW = $clog2(ELS + 1);
  localparam int ELW = $clog2(ELS);

`ifdef VEC_SEQ_OVF_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic           clk_i = 1'b0;
  logic           reset_n_i;
  logic           v_i;
  logic           ready_o;
  logic [OPW-1:0] op_i;
  logic [VLW-1:0] vlen_i;
  logic [AW-1:0]  vd_i, vs1_i, vs2_i;
  logic           rd_v_o;
  logic [AW-1:0]  rd_reg_a_o, rd_reg_b_o;
  logic [ELW-1:0] rd_el_o;
  logic [VDW-1:0] rd_data_a_i, rd_data_b_i;
  logic [VDW-1:0] alu_a_o, alu_b_o;
  logic [OPW-1:0] alu_op_o;
  logic [VDW-1:0] alu_result_i;
  logic           alu_overflow_i, alu_zero_i, alu_negative_i;
  logic           wr_v_o;
  logic [AW-1:0]  wr_reg_o;
  logic [ELW-1:0] wr_el_o;
  logic [VDW-1:0] wr_data_o;
  logic           done_v_o;
  logic           done_yumi_i;
  logic           flag_overflow_o, flag_all_zero_o, flag_any_negative_o;
  logic           trap_o;
  logic [ELW-1:0] trap_el_o;

  vec_alu_sequencer #(
    .vdw_p(VDW), .op_width_p(OPW), .els_p(ELS), .addr_width_p(AW)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .v_i(v_i), .ready_o(ready_o), .op_i(op_i), .vlen_i(vlen_i),
    .vd_i(vd_i), .vs1_i(vs1_i), .vs2_i(vs2_i),
    .rd_v_o(rd_v_o), .rd_reg_a_o(rd_reg_a_o), .rd_reg_b_o(rd_reg_b_o), .rd_el_o(rd_el_o),
    .rd_data_a_i(rd_data_a_i), .rd_data_b_i(rd_data_b_i),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_op_o(alu_op_o),
    .alu_result_i(alu_result_i), .alu_overflow_i(alu_overflow_i),
    .alu_zero_i(alu_zero_i), .alu_negative_i(alu_negative_i),
    .wr_v_o(wr_v_o), .wr_reg_o(wr_reg_o), .wr_el_o(wr_el_o), .wr_data_o(wr_data_o),
    .done_v_o(done_v_o), .done_yumi_i(done_yumi_i),
    .flag_overflow_o(flag_overflow_o), .flag_all_zero_o(flag_all_zero_o),
    .flag_any_negative_o(flag_any_negative_o),
    .trap_o(trap_o), .trap_el_o(trap_el_o)
  );

  initial forever #5 clk_i = ~clk_i;

  int cyc = 0;
  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // ALU stand-in: add with carry-out, sub with borrow, as the overflow flag.
  logic [VDW:0] alu_wide;
  always_comb begin
    alu_wide = '0;
    if (alu_op_o == 1'b0) alu_wide = {1'b0, alu_a_o} + {1'b0, alu_b_o};
    else                  alu_wide = {1'b0, alu_a_o} - {1'b0, alu_b_o};
    alu_result_i   = alu_wide[VDW-1:0];
    alu_overflow_i = alu_wide[VDW];
    alu_zero_i     = (alu_wide[VDW-1:0] == '0);
    alu_negative_i = alu_wide[VDW-1];
  end

  // VRF model: writes commit on the strobe, reads answer one cycle after the request.
  typedef struct {int stamp; int rg; int el; logic [VDW-1:0] data;} wr_t;
  logic [VDW-1:0] vrf [16][ELS];
  wr_t            wq[$];
  int             rd_cnt = 0;
  bit             rd_pend = 0;
  logic [VDW-1:0] pa, pb;

  initial forever begin
    @(negedge clk_i);
    if (wr_v_o === 1'b1) begin
      vrf[wr_reg_o][wr_el_o] = wr_data_o;
      wq.push_back('{cyc, int'(wr_reg_o), int'(wr_el_o), wr_data_o});
    end
    if (rd_v_o === 1'b1) begin
      rd_cnt++;
      rd_pend = 1;
      pa = vrf[rd_reg_a_o][rd_el_o];
      pb = vrf[rd_reg_b_o][rd_el_o];
    end else begin
      rd_pend = 0;
    end
  end

  initial begin
    rd_data_a_i = '0;
    rd_data_b_i = '0;
    forever begin
      @(posedge clk_i);
      #1;
      if (rd_pend) begin
        rd_data_a_i = pa;
        rd_data_b_i = pb;
      end else begin
        rd_data_a_i = $urandom;
        rd_data_b_i = $urandom;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {ready_o, rd_v_o, wr_v_o, done_v_o, flag_overflow_o,
                          flag_all_zero_o, flag_any_negative_o, trap_o}, 64'b1000_0100);
    check({tag, "_idx"}, {rd_reg_a_o, rd_reg_b_o, rd_el_o, wr_reg_o, wr_el_o, alu_op_o, trap_el_o}, 64'd0);
    check({tag, "_dat"}, {alu_a_o, alu_b_o}, 64'd0);
    check({tag, "_wrd"}, wr_data_o, 64'd0);
  endtask

  // Issue one instruction and check every write, the done latency, flags and trap report.
  task automatic run_instr(input logic op, input int vlen, input int vd, input int vs1,
                           input int vs2, input int hold);
    logic [VDW-1:0] sa [ELS];
    logic [VDW-1:0] sb [ELS];
    logic [VDW-1:0] er [ELS];
    longint s;
    logic   ov, eo, ez, en;
    int     n, neff, t, acc, dstamp, nrd;
    n = (vlen > ELS) ? ELS : vlen;
    neff = 0; t = -1; eo = 0; ez = 1; en = 0;
    for (int i = 0; i < n; i++) begin
      sa[i] = vrf[vs1][i];
      sb[i] = vrf[vs2][i];
    end
    for (int i = 0; i < n; i++) begin
      if (op) begin
        er[i] = sa[i] - sb[i];
        ov = (sa[i] < sb[i]);
      end else begin
        s = longint'(sa[i]) + longint'(sb[i]);
        er[i] = s[31:0];
        ov = (s > 64'hFFFF_FFFF);
      end
      eo = eo | ov;
      ez = ez & (er[i] == '0);
      en = en | er[i][VDW-1];
      neff = i + 1;
      if (TRAP && ov) begin
        t = i;
        break;
      end
    end
    // The overflow is seen two cycles after its read, by which time two more reads may be out.
    nrd = (t >= 0) ? ((n < t + 3) ? n : t + 3) : n;

    @(negedge clk_i);
    #1;
    rd_cnt = 0;
    wq.delete();
    check("ready_idle", ready_o, 1);
    v_i = 1; op_i = op; vlen_i = VLW'(vlen);
    vd_i = AW'(vd); vs1_i = AW'(vs1); vs2_i = AW'(vs2);
    @(posedge clk_i);
    #1;
    acc = cyc;
    v_i = 0;
    vlen_i = VLW'($urandom); vd_i = AW'($urandom);

    dstamp = -1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk_i);
      #1;
      if (done_v_o === 1'b1) begin
        dstamp = cyc;
        break;
      end
    end
    // done_v_o is high before edge accept+neff+4, i.e. after edge accept+neff+3.
    check("done_latency", 64'(dstamp - acc), 64'((neff == 0) ? 0 : neff + 3));
    check("ready_busy", ready_o, 0);
    check("wr_count", 64'(wq.size()), 64'(neff));
    for (int i = 0; i < neff && i < wq.size(); i++) begin
      check("wr_data", wq[i].data, er[i]);
      check("wr_pos", {16'(wq[i].stamp - acc), 16'(wq[i].rg), 16'(wq[i].el)},
                      {16'(3 + i), 16'(vd), 16'(i)});
    end
    check("rd_count", 64'(rd_cnt), 64'(nrd));
    check("flags", {flag_overflow_o, flag_all_zero_o, flag_any_negative_o}, {eo, ez, en});
    check("trap", {trap_o, 8'(trap_el_o)}, {(t >= 0), 8'((t >= 0) ? t : 0)});

    // While waiting for the consumer, a new request must be ignored and the report held.
    v_i = 1;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk_i);
      #1;
      check("hold", {done_v_o, ready_o, flag_overflow_o, flag_all_zero_o, flag_any_negative_o},
                    {1'b1, 1'b0, eo, ez, en});
    end
    v_i = 0;
    done_yumi_i = 1;
    @(negedge clk_i);
    #1;
    done_yumi_i = 0;
    check("release", {done_v_o, ready_o}, 2'b01);
    check("no_extra", {16'(wq.size()), 16'(rd_cnt)}, {16'(neff), 16'(nrd)});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, k;
    for (int r = 0; r < 16; r++)
      for (int e = 0; e < ELS; e++) vrf[r][e] = $urandom >> $urandom_range(0, 31);
    v_i = 0; op_i = '0; vlen_i = '0; vd_i = '0; vs1_i = '0; vs2_i = '0; done_yumi_i = 0;
    reset_n_i = 1;
    #2 reset_n_i = 0;
    #1 check_reset_outputs("reset_async");
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1;
    check_reset_outputs("reset_idle");

    // Add, four elements.
    for (int i = 0; i < 4; i++) begin
      vrf[1][i] = 32'(i + 1);
      vrf[2][i] = 32'(10 * (i + 1));
    end
    run_instr(1'b0, 4, 3, 1, 2, 1);
    check("add_vec", {vrf[3][0][15:0], vrf[3][1][15:0], vrf[3][2][15:0], vrf[3][3][15:0]},
                     {16'd11, 16'd22, 16'd33, 16'd44});

    // Sub yielding all zeros.
    vrf[4][0] = 5; vrf[4][1] = 7; vrf[5][0] = 5; vrf[5][1] = 7;
    run_instr(1'b1, 2, 6, 4, 5, 0);

    // Zero-length with a long hold.
    run_instr(1'b0, 0, 2, 3, 4, 5);

    // Over-long request, in place.
    run_instr(1'b0, 20, 7, 7, 8, 0);

    // Overflow at element 2 of six.
    for (int i = 0; i < 6; i++) begin
      vrf[9][i] = 32'(i + 100);
      vrf[10][i] = 32'(i);
    end
    vrf[9][2] = 32'hFFFF_FFFF;
    vrf[10][2] = 32'd1;
    run_instr(1'b0, 6, 11, 9, 10, 0);

    // Reset in the middle of a run after two reads.
    @(negedge clk_i);
    #1;
    rd_cnt = 0;
    wq.delete();
    v_i = 1; op_i = 1'b0; vlen_i = VLW'(8); vd_i = 4'd12; vs1_i = 4'd1; vs2_i = 4'd2;
    @(posedge clk_i);
    #1;
    v_i = 0;
    acc = cyc;
    k = 0;
    while (rd_cnt < 2 && k < 20) begin
      @(negedge clk_i);
      #1;
      k++;
    end
    check("pre_reset_reads", 64'(rd_cnt), 64'd2);
    reset_n_i = 0;
    #1 check_reset_outputs("reset_mid");
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1;
    repeat (8) @(negedge clk_i);
    #1;
    check("post_reset_quiet", {16'(wq.size()), 16'(rd_cnt), 1'b0, ready_o}, {16'd0, 16'd2, 2'b01});
    run_instr(1'b0, 5, 12, 1, 2, 0);

    // Randomized instructions.
    for (int r = 0; r < 24; r++) begin
      run_instr(1'($urandom), int'($urandom_range(0, 20)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vec_alu_sequencer.md
Name: vec_alu_sequencer

Overview:
- Initiator side of the vector ALU operand interface.
- Accepts one vector instruction (op, length, register indices) over a valid/ready handshake.
- Streams element pairs from the vector register file (VRF) into the ALU and writes each result back to the VRF.
- Reports accumulated flags on a done handshake. Sits between the vector issue stage and the ALU/VRF.

Parameters:
vdw_p, 32, element data width; matches ALU width
op_width_p, 1, ALU op width (0 = add, 1 = sub)
els_p, 16, max elements per vector register
addr_width_p, 4, VRF register index width

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
v_i  in  1  instruction valid
ready_o  out  1  sequencer can accept an instruction
op_i  in  op_width_p  ALU op for the whole vector
vlen_i  in  $clog2(els_p+1)  element count
vd_i / vs1_i / vs2_i  in  addr_width_p  destination / source A / source B register
rd_v_o  out  1  VRF read request
rd_reg_a_o / rd_reg_b_o  out  addr_width_p  source registers
rd_el_o  out  $clog2(els_p)  element index
rd_data_a_i / rd_data_b_i  in  vdw_p  read data, valid 1 cycle after rd_v_o
alu_a_o / alu_b_o  out  vdw_p  ALU operands (registered)
alu_op_o  out  op_width_p  ALU op (registered)
alu_result_i  in  vdw_p  ALU result (combinational from operands)
alu_overflow_i / alu_zero_i / alu_negative_i  in  1  ALU flags
wr_v_o  out  1  VRF write strobe
wr_reg_o  out  addr_width_p  destination register
wr_el_o  out  $clog2(els_p)  element index
wr_data_o  out  vdw_p  write data
done_v_o  out  1  instruction complete; held until done_yumi_i
done_yumi_i  in  1  completion consumed
flag_overflow_o / flag_all_zero_o / flag_any_negative_o  out  1  sticky flags, valid with done_v_o
trap_o  out  1  aborted on overflow (feature only)
trap_el_o  out  $clog2(els_p)  element index of the trap

Behaviour:
- Reset: all outputs 0 except ready_o = 1 and flag_all_zero_o = 1. FSM goes to IDLE; the pipeline is flushed.
- Reset mid-instruction: no further rd_v_o or wr_v_o; any in-flight writes are dropped.
- FSM states:
  - IDLE: ready_o = 1. v_i & ready_o latches op, vd, vs1, vs2, and min(vlen_i, els_p). Goes to RUN, or to DONE when the clamped vlen is 0.
  - RUN: issues rd_v_o with rd_el_o = 0, 1, 2, ... for consecutive cycles (1 element/cycle). After the last index is issued, goes to DRAIN.
  - DRAIN: no reads. Waits until the last write has issued, then goes to DONE.
  - DONE: done_v_o = 1, flags stable. On done_yumi_i, returns to IDLE with ready_o = 1 in the next cycle. No back-to-back overlap of instructions.
- Pipeline for element i, with the read issued in cycle c:
  - c+1: read data captured into alu_a_o, alu_b_o and alu_op_o.
  - c+2: alu_result_i and flags sampled into the write registers.
  - c+3: wr_v_o = 1, with wr_el_o = i and wr_reg_o = vd.
- Latency: done_v_o rises vlen+4 cycles after the accept edge (vlen ≥ 1); 1 cycle after accept for vlen = 0.
- Each element is written exactly once and only after it is read, so vd == vs1 or vd == vs2 (in place) is legal.
- Sticky flags:
  - Cleared on accept: overflow = 0, all_zero = 1, any_negative = 0.
  - Updated per element at the write capture: overflow |= ovf, all_zero &= zero, any_negative |= neg.
  - vlen = 0 leaves the cleared values.
- vlen_i > els_p is clamped to els_p. Indices never wrap.
- ready_o = 0 outside IDLE; v_i is ignored there.

Optional Feature:
VEC_SEQ_OVF_TRAP_EN
- Defined:
  - On the first element whose alu_overflow_i = 1, that element is still written.
  - No further reads are issued; FSM goes to DRAIN.
  - Elements already in flight behind the trapping element are squashed: no wr_v_o for them.
  - DONE reports trap_o = 1 and trap_el_o = the trapping index.
- Undefined: all elements are processed; trap_o and trap_el_o are tied to 0.

Test Plan:
- Add, vlen = 4, vs1 = {1,2,3,4}, vs2 = {10,20,30,40} -> writes {11,22,33,44} to vd at els 0-3 on 4 consecutive cycles; done at accept+8; overflow = 0, all_zero = 0, any_negative = 0.
- Sub, vlen = 2, vs1 = {5,7}, vs2 = {5,7} -> writes {0,0}; all_zero = 1, any_negative = 0.
- vlen = 0 -> no rd_v_o, no wr_v_o; done_v_o 1 cycle after accept; flags 0/1/0. Hold done_yumi_i low for 5 cycles -> done_v_o and flags stable; ready_o stays 0.
- vlen_i = 20 with els_p = 16 -> exactly 16 writes (els 0-15); in place with vd = vs1 gives correct results.
- Add, 0xFFFFFFFF + 1 at el 2 of vlen = 6 -> overflow = 1; with trap enabled: writes only els 0-2, trap_o = 1, trap_el_o = 2.
- Assert reset_n_i low in RUN after 2 reads -> outputs reset asynchronously; no wr_v_o afterwards; a new instruction after reset completes correctly.
